// File: rtl/div_seq_ctrl.sv
// Sequencing and staging for a 32-bit DIV/DIVU using a settle-timed combinational array divide.
// Optional overflow flag for signed -2^31 / -1 is enabled by defining DIV_OVF_DET_EN.
module div_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [31:0] ZERO_Q_VALUE  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] q_out,
  output logic [31:0] r_out,
  output logic        div_by_zero
`ifdef DIV_OVF_DET_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StPrep, StSettle, StFix, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       dividend_q;
  logic [31:0]       divisor_q;
  logic              signed_q;
  logic              sa_q;
  logic              sb_q;
  logic [31:0]       mag_a_q;
  logic [31:0]       mag_b_q;
  logic [31:0]       qa;
  logic [31:0]       ra;

  // Array divider; its inputs are register-held from PREP through FIX so it can settle.
  always_comb begin
    qa = '0;
    ra = '0;
    if (mag_b_q != '0) begin
      qa = mag_a_q / mag_b_q;
      ra = mag_a_q % mag_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      q_out       <= '0;
      r_out       <= '0;
      cnt_q       <= '0;
`ifdef DIV_OVF_DET_EN
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            signed_q   <= signed_op;
            busy       <= 1'b1;
`ifdef DIV_OVF_DET_EN
            ovf        <= 1'b0;
`endif
            if (divisor == '0) begin
              q_out       <= ZERO_Q_VALUE;
              r_out       <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StPrep;
            end
          end
        end
        StPrep: begin
          sa_q    <= dividend_q[31] & signed_q;
          sb_q    <= divisor_q[31] & signed_q;
          mag_a_q <= (dividend_q[31] & signed_q) ? -dividend_q : dividend_q;
          mag_b_q <= (divisor_q[31] & signed_q) ? -divisor_q : divisor_q;
          cnt_q   <= CntW'(SETTLE_CYCLES - 1);
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFix: begin
          // Truncating division: remainder follows the dividend's sign.
          q_out       <= (sa_q ^ sb_q) ? -qa : qa;
          r_out       <= sa_q ? -ra : ra;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
`ifdef DIV_OVF_DET_EN
          ovf         <= signed_q && (dividend_q == 32'h8000_0000) &&
                         (divisor_q == 32'hFFFF_FFFF);
`endif
          state_q     <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: expectations are queued at issue and checked on done.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q_out;
  logic [31:0] r_out;
  logic        div_by_zero;
`ifdef DIV_OVF_DET_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .q_out       (q_out),
    .r_out       (r_out),
    .div_by_zero (div_by_zero)
`ifdef DIV_OVF_DET_EN
    ,
    .ovf         (ovf)
`endif
  );

  // Reference model: wide signed arithmetic, independent of the magnitude/fix-up scheme.
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    e = '0;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.q = 32'(sa / sbv);
      e.r = 32'(sa % sbv);
`ifdef DIV_OVF_DET_EN
      e.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`endif
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Result checker: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (clr && done) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got q=%h r=%h, no result expected", q_out, r_out);
      end else begin
        e = sb_q.pop_front();
        if (q_out !== e.q || r_out !== e.r || div_by_zero !== e.dbz
`ifdef DIV_OVF_DET_EN
            || ovf !== e.ovf
`endif
            ) begin
          fails++;
          $display("FAIL result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                   q_out, r_out, div_by_zero, e.q, e.r, e.dbz);
        end
      end
    end
  end

  // Issue one op from IDLE, check latency and busy window; returns one edge after DONE.
  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    int  got;
    logic busy_ok;
    got     = -1;
    busy_ok = 1'b1;
    sb_q.push_back(model(s, a, b));
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got = k;
        break;
      end
      @(posedge clk);
    end
    tests++;
    if (got != lat) begin
      fails++;
      $display("FAIL %s_latency: done after edge %0d, expected edge %0d", name, got, lat);
    end
    tests++;
    if (!busy_ok) begin
      fails++;
      $display("FAIL %s_busy_window: busy dropped before done, expected 1", name);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_after: busy=%b done=%b, expected 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, div_by_zero, q_out, r_out} !== 67'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, expected all 0",
               busy, done, div_by_zero, q_out, r_out);
    end
`ifdef DIV_OVF_DET_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b, expected 0", ovf);
    end
`endif
    clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 6);
    run_op("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 6);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 6);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 6);
    run_op("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 6);
  endtask

  task automatic test_div_zero();
    run_op("div_zero", 1'b1, 32'h0000_1234, 32'd0, 0);
  endtask

  task automatic test_busy_ignore();
    int got;
    got = -1;
    sb_q.push_back(model(1'b0, 32'd50, 32'd5));
    signed_op = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 3; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = k;
        break;
      end
      @(posedge clk);
    end
    tests++;
    if (got != 6) begin
      fails++;
      $display("FAIL busy_ignore_latency: done after edge %0d, expected edge 6", got);
    end
    @(posedge clk);
    #1;
    run_op("after_ignore", 1'b0, 32'd9, 32'd3, 6);
  endtask

  task automatic test_clr_abort();
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, div_by_zero, q_out, r_out} !== 67'd0) begin
      fails++;
      $display("FAIL clr_abort: busy=%b done=%b dbz=%b q=%h r=%h, expected all 0",
               busy, done, div_by_zero, q_out, r_out);
    end
    clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    run_op("after_clr", 1'b0, 32'd20, 32'd6, 6);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6);
    run_op("after_ovf", 1'b1, 32'h8000_0000, 32'd2, 6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i[0]) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i == 5) b = 32'hFFFF_FFFF;
      run_op("b2b", i[1], a, b, (b == 32'd0) ? 0 : 6);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_busy_ignore();
    test_clr_abort();
    test_overflow();
    test_back_to_back();
    repeat (3) @(posedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL outstanding: %0d results never delivered, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
